// File: rtl/writeback_controller.sv
// Writeback arbiter: drives one scalar-file and one vector-file write per cycle, parking
// vector-pipe results that lose a port collision in per-lane replay FIFOs.

module writeback_lane #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 5,
   parameter int BUF_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         s_wr_en,
   input  logic [ADDR_W-1:0]            s_addr,
   input  logic [DATA_W-1:0]            s_data,
   input  logic                         v_wr_en,
   input  logic [ADDR_W-1:0]            v_addr,
   input  logic [DATA_W-1:0]            v_data,
   input  logic                         wb_sel,
   input  logic                         park,
   input  logic                         replay,
   output logic                         wr_en,
   output logic [ADDR_W-1:0]            wr_addr,
   output logic [DATA_W-1:0]            wr_data,
   output logic [$clog2(BUF_DEPTH):0]   count,
   output logic                         error
);

   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(BUF_DEPTH);

   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_SCALAR,
      SRC_VECTOR,
      SRC_FIFO
   } wb_src_e;

   logic [ADDR_W+DATA_W-1:0] fifo_mem [BUF_DEPTH];
   logic [PTR_W-1:0]         head_ptr;
   logic [PTR_W-1:0]         tail_ptr;
   logic [CNT_W-1:0]         count_q;
   logic                     error_q;

   logic                     fifo_empty;
   logic                     fifo_full;
   logic [ADDR_W-1:0]        head_addr;
   logic [DATA_W-1:0]        head_data;

   wb_src_e                  src;
   logic                     pop;
   logic                     push_req;
   logic                     push;
   logic                     overflow;
   logic                     underflow;
   logic                     illegal;

   assign fifo_empty             = (count_q == '0);
   assign fifo_full              = (count_q == FULL_COUNT);
   assign {head_addr, head_data} = fifo_mem[head_ptr];

   // Priority: replay, park, vector-select (drain older parked entries first), scalar default.
   always_comb begin
      src       = SRC_NONE;
      pop       = 1'b0;
      push_req  = 1'b0;
      underflow = 1'b0;
      illegal   = (park & wb_sel) | (replay & park);
      if (replay) begin
         push_req = v_wr_en;
         if (fifo_empty) begin
            underflow = 1'b1;
         end else begin
            pop = 1'b1;
            src = SRC_FIFO;
         end
      end else if (park) begin
         push_req = v_wr_en;
         if (s_wr_en) src = SRC_SCALAR;
      end else if (wb_sel) begin
         if (!fifo_empty) begin
            pop      = 1'b1;
            push_req = v_wr_en;
            src      = SRC_FIFO;
         end else if (v_wr_en) begin
            src = SRC_VECTOR;
         end
      end else if (s_wr_en) begin
         src = SRC_SCALAR;
      end
   end

   // A simultaneous pop frees the slot, so only a push into a full FIFO without a pop overflows.
   assign overflow = push_req & fifo_full & ~pop;
   assign push     = push_req & ~overflow;

   always_ff @(posedge clk) begin
      if (push) fifo_mem[tail_ptr] <= {v_addr, v_data};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count_q  <= '0;
         error_q  <= 1'b0;
      end else begin
         if (pop)  head_ptr <= head_ptr + PTR_W'(1);
         if (push) tail_ptr <= tail_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
         error_q <= error_q | illegal | underflow | overflow;
      end
   end

   // Address and data hold their last value while no write is issued.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         wr_en <= (src != SRC_NONE);
         case (src)
            SRC_SCALAR: begin
               wr_addr <= s_addr;
               wr_data <= s_data;
            end
            SRC_VECTOR: begin
               wr_addr <= v_addr;
               wr_data <= v_data;
            end
            SRC_FIFO: begin
               wr_addr <= head_addr;
               wr_data <= head_data;
            end
            default: begin
               wr_addr <= wr_addr;
               wr_data <= wr_data;
            end
         endcase
      end
   end

   assign count = count_q;
   assign error = error_q;

endmodule

module writeback_controller #(
   parameter int SDATA_W   = 32,
   parameter int VDATA_W   = 128,
   parameter int ADDR_W    = 5,
   parameter int BUF_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         s_reg_wr_en,
   input  logic                         s_vec_wr_en,
   input  logic [ADDR_W-1:0]            s_wr_addr,
   input  logic [SDATA_W-1:0]           s_reg_data,
   input  logic [VDATA_W-1:0]           s_vec_data,
   input  logic                         v_reg_wr_en,
   input  logic                         v_vec_wr_en,
   input  logic [ADDR_W-1:0]            v_wr_addr,
   input  logic [SDATA_W-1:0]           v_reg_data,
   input  logic [VDATA_W-1:0]           v_vec_data,
   input  logic                         register_wb_sel,
   input  logic                         vector_wb_sel,
   input  logic                         buffer_register,
   input  logic                         buffer_vector,
   input  logic                         buffer_register_sel,
   input  logic                         buffer_vector_sel,
   output logic                         rf_wr_en,
   output logic [ADDR_W-1:0]            rf_wr_addr,
   output logic [SDATA_W-1:0]           rf_wr_data,
   output logic                         vf_wr_en,
   output logic [ADDR_W-1:0]            vf_wr_addr,
   output logic [VDATA_W-1:0]           vf_wr_data,
   output logic [$clog2(BUF_DEPTH):0]   reg_buf_count,
   output logic [$clog2(BUF_DEPTH):0]   vec_buf_count,
   output logic                         wb_error
);

   logic reg_error;
   logic vec_error;

   writeback_lane #(
      .DATA_W    (SDATA_W),
      .ADDR_W    (ADDR_W),
      .BUF_DEPTH (BUF_DEPTH)
   ) u_reg_lane (
      .clk     (clk),
      .rst     (rst),
      .s_wr_en (s_reg_wr_en),
      .s_addr  (s_wr_addr),
      .s_data  (s_reg_data),
      .v_wr_en (v_reg_wr_en),
      .v_addr  (v_wr_addr),
      .v_data  (v_reg_data),
      .wb_sel  (register_wb_sel),
      .park    (buffer_register),
      .replay  (buffer_register_sel),
      .wr_en   (rf_wr_en),
      .wr_addr (rf_wr_addr),
      .wr_data (rf_wr_data),
      .count   (reg_buf_count),
      .error   (reg_error)
   );

   writeback_lane #(
      .DATA_W    (VDATA_W),
      .ADDR_W    (ADDR_W),
      .BUF_DEPTH (BUF_DEPTH)
   ) u_vec_lane (
      .clk     (clk),
      .rst     (rst),
      .s_wr_en (s_vec_wr_en),
      .s_addr  (s_wr_addr),
      .s_data  (s_vec_data),
      .v_wr_en (v_vec_wr_en),
      .v_addr  (v_wr_addr),
      .v_data  (v_vec_data),
      .wb_sel  (vector_wb_sel),
      .park    (buffer_vector),
      .replay  (buffer_vector_sel),
      .wr_en   (vf_wr_en),
      .wr_addr (vf_wr_addr),
      .wr_data (vf_wr_data),
      .count   (vec_buf_count),
      .error   (vec_error)
   );

   assign wb_error = reg_error | vec_error;

endmodule
